// File: rtl/systolic_skew_buffer_if.sv
// Stream interface of the systolic skew/deskew buffer.
// master: producer/consumer side (bench or array edge); slave: the buffer itself.
interface systolic_skew_buffer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned CNT_W      = $clog2(LANES + 1)
);
  logic                          mode_i;
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*DATA_WIDTH-1:0]   data_i;
  logic                          out_ready;
  logic [LANES-1:0]              out_valid;
  logic [LANES*DATA_WIDTH-1:0]   data_o;
  logic                          mode_o;
  logic [CNT_W-1:0]              wave_count;
  logic                          busy;

  modport master (
    output mode_i, in_valid, data_i, out_ready,
    input  in_ready, out_valid, data_o, mode_o, wave_count, busy
  );

  modport slave (
    input  mode_i, in_valid, data_i, out_ready,
    output in_ready, out_valid, data_o, mode_o, wave_count, busy
  );
endinterface

// File: rtl/systolic_skew_buffer.sv
// Lane skew/deskew buffer: lane i is delayed by i (skew, mode 0) or LANES-1-i
// (deskew, mode 1) advancing cycles, plus one registered output stage.
// out_ready low freezes everything; a mode change is taken only when empty.
// Optional feature macro: SKEW_ZERO_FILL_EN (bubbles carry 0, invalid lanes read 0).
module systolic_skew_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned CNT_W      = $clog2(LANES + 1)
) (
  input logic                   clk,
  input logic                   sync_reset,
  systolic_skew_buffer_if.slave bus
);

  localparam int unsigned Stages = LANES - 1;

  typedef logic [DATA_WIDTH-1:0] lane_t;

  // Per-lane delay chain; valids are shared because every lane carries the same vector.
  lane_t              stage_q [LANES][Stages];
  logic [Stages-1:0]  vld_q;
  lane_t              out_q   [LANES];
  logic [LANES-1:0]   out_vld_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mode_q;

  logic               in_ready;
  logic               accept;
  logic               advance;
  logic               dec;
  logic [LANES-1:0]   tap_vld;
  lane_t              taps    [LANES][LANES];
  lane_t              nxt_data [LANES];
  logic [LANES-1:0]   nxt_vld;
  logic [CNT_W-1:0]   cnt_d;

  function automatic int unsigned lane_delay(input int unsigned lane, input logic mode);
    return mode ? (LANES - 1 - lane) : lane;
  endfunction

  // Handshake, tap selection per lane and wavefront count next-state.
  always_comb begin
    in_ready = bus.out_ready && (bus.mode_i == mode_q);
    accept   = bus.in_valid && in_ready;
    advance  = bus.out_ready;
    // Tap LANES-1 feeds the longest lane in both modes.
    dec      = advance && vld_q[Stages-1];
    tap_vld  = {vld_q, accept};
    for (int unsigned l = 0; l < LANES; l++) begin
      taps[l][0] = bus.data_i[l*DATA_WIDTH +: DATA_WIDTH];
`ifdef SKEW_ZERO_FILL_EN
      if (!accept) taps[l][0] = '0;
`endif
      for (int unsigned k = 1; k < LANES; k++) begin
        taps[l][k] = stage_q[l][k-1];
      end
      nxt_data[l] = '0;
      nxt_vld[l]  = 1'b0;
      for (int unsigned k = 0; k < LANES; k++) begin
        if (k == lane_delay(l, mode_q)) begin
          nxt_data[l] = taps[l][k];
          nxt_vld[l]  = tap_vld[k];
        end
      end
`ifdef SKEW_ZERO_FILL_EN
      if (!nxt_vld[l]) nxt_data[l] = '0;
`endif
    end
    cnt_d = cnt_q;
    if (accept && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept && dec) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Shift chains, output stage, count and mode register.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        for (int unsigned s = 0; s < Stages; s++) begin
          stage_q[l][s] <= '0;
        end
        out_q[l] <= '0;
      end
      vld_q     <= '0;
      out_vld_q <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      if (advance) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          for (int unsigned s = 0; s < Stages; s++) begin
            stage_q[l][s] <= taps[l][s];
          end
          out_q[l] <= nxt_data[l];
        end
        vld_q     <= tap_vld[Stages-1:0];
        out_vld_q <= nxt_vld;
        cnt_q     <= cnt_d;
      end
      // Mode switch ignores out_ready so a stalled empty buffer can still change mode.
      if ((bus.mode_i != mode_q) && (cnt_q == '0)) begin
        mode_q <= bus.mode_i;
      end
    end
  end

  // Output packing.
  always_comb begin
    bus.data_o = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      bus.data_o[l*DATA_WIDTH +: DATA_WIDTH] = out_q[l];
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_vld_q;
  assign bus.mode_o     = mode_q;
  assign bus.wave_count = cnt_q;
  assign bus.busy       = (cnt_q != '0);

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Scoreboard bench for systolic_skew_buffer (LANES=4, DATA_WIDTH=8).
// Stimulus pushes expected lane bytes on accept; a monitor pops them on each consumed output.
module tb_systolic_skew_buffer;
  localparam int unsigned DW    = 8;
  localparam int unsigned LANES = 4;

  logic clk = 1'b0;
  logic sync_reset;
  always #5 clk = ~clk;

  systolic_skew_buffer_if #(.DATA_WIDTH(DW), .LANES(LANES)) bus ();

  systolic_skew_buffer #(.DATA_WIDTH(DW), .LANES(LANES)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [LANES][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: an output is consumed when presented with out_ready high.
  always @(negedge clk) begin
    if (!sync_reset) begin
      for (int l = 0; l < LANES; l++) begin
        if (bus.out_valid[l] && bus.out_ready) begin
          if (exp_q[l].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL lane%0d unexpected output 0x%0h, required none at %0t",
                     l, bus.data_o[l*DW +: DW], $time);
          end else begin
            check($sformatf("lane%0d data", l), 32'(bus.data_o[l*DW +: DW]),
                  32'(exp_q[l].pop_front()));
          end
        end
`ifdef SKEW_ZERO_FILL_EN
        if (!bus.out_valid[l]) begin
          check($sformatf("lane%0d zero fill", l), 32'(bus.data_o[l*DW +: DW]), 32'h0);
        end
`endif
      end
    end
  end

  function automatic logic [31:0] vec(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // One cycle: drive inputs, check in_ready mid-cycle, record expected data on accept.
  task automatic drive(input logic v, input logic [31:0] d, input logic ordy,
                       input logic exp_rdy);
    bus.in_valid  = v;
    bus.data_i    = d;
    bus.out_ready = ordy;
    @(negedge clk);
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (v && exp_rdy) begin
      for (int l = 0; l < LANES; l++) exp_q[l].push_back(d[l*DW +: DW]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic post(input string tag, input logic [3:0] ov, input logic [2:0] cnt);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, " wave_count"}, 32'(bus.wave_count), 32'(cnt));
    check({tag, " busy"}, 32'(bus.busy), 32'(cnt != 3'd0));
  endtask

  logic [3:0] ov_skew [4]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] ov_desk [4]   = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [2:0] cnt_one [4]   = '{3'd1, 3'd1, 3'd1, 3'd0};
  // Stream: {out_ready, in_valid, n}; stall on cycles 3..5.
  logic [5:0] strm [15] = '{
    {1'b1, 1'b1, 4'd0}, {1'b1, 1'b1, 4'd1}, {1'b1, 1'b1, 4'd2}, {1'b0, 1'b1, 4'd3},
    {1'b0, 1'b1, 4'd3}, {1'b0, 1'b1, 4'd3}, {1'b1, 1'b1, 4'd3}, {1'b1, 1'b1, 4'd4},
    {1'b1, 1'b1, 4'd5}, {1'b1, 1'b0, 4'd0}, {1'b1, 1'b0, 4'd0}, {1'b1, 1'b0, 4'd0},
    {1'b1, 1'b0, 4'd0}, {1'b1, 1'b0, 4'd0}, {1'b1, 1'b0, 4'd0}};
  logic [2:0] strm_cnt [15] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
                                3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [2:0] tog_cnt [4]  = '{3'd2, 3'd1, 3'd0, 3'd0};
  logic       tog_mode [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [5:0] s;
    sync_reset    = 1'b1;
    bus.mode_i    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_i    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sync_reset = 1'b0;
    post("reset", 4'b0000, 3'd0);
    check("reset data_o", bus.data_o, 32'h0);
    check("reset mode_o", 32'(bus.mode_o), 32'h0);

    // Skew, single vector.
    drive(1'b1, vec(8'h10), 1'b1, 1'b1);
    post("skew c0", ov_skew[0], cnt_one[0]);
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      post($sformatf("skew c%0d", k), ov_skew[k], cnt_one[k]);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    post("skew idle", 4'b0000, 3'd0);

    // Back-to-back stream with a three-cycle stall.
    for (int k = 0; k < 15; k++) begin
      s = strm[k];
      drive(s[4], {4{8'h20 + {4'h0, s[3:0]}}}, s[5], s[5]);
      check($sformatf("stream c%0d wave_count", k), 32'(bus.wave_count), 32'(strm_cnt[k]));
      check("stream count bound", 32'(bus.wave_count <= 3'(LANES)), 32'h1);
    end

    // Mode toggle with two vectors in flight.
    drive(1'b1, vec(8'h30), 1'b1, 1'b1);
    drive(1'b1, vec(8'h40), 1'b1, 1'b1);
    check("toggle start wave_count", 32'(bus.wave_count), 32'h2);
    bus.mode_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'hEEEE_EEEE, 1'b1, 1'b0);
      check($sformatf("toggle c%0d wave_count", k), 32'(bus.wave_count), 32'(tog_cnt[k]));
      check($sformatf("toggle c%0d mode_o", k), 32'(bus.mode_o), 32'(tog_mode[k]));
    end

    // Deskew, single vector (accepted on the first cycle in_ready returns).
    drive(1'b1, vec(8'h10), 1'b1, 1'b1);
    post("deskew c0", ov_desk[0], cnt_one[0]);
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      post($sformatf("deskew c%0d", k), ov_desk[k], cnt_one[k]);
    end

    // Reset with three vectors in flight.
    drive(1'b1, vec(8'h50), 1'b1, 1'b1);
    drive(1'b1, vec(8'h60), 1'b1, 1'b1);
    drive(1'b1, vec(8'h70), 1'b1, 1'b1);
    check("pre-reset wave_count", 32'(bus.wave_count), 32'h3);
    bus.in_valid = 1'b0;
    bus.mode_i   = 1'b0;
    sync_reset   = 1'b1;
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    for (int l = 0; l < LANES; l++) exp_q[l].delete();
    post("mid reset", 4'b0000, 3'd0);
    check("mid reset data_o", bus.data_o, 32'h0);
    check("mid reset mode_o", 32'(bus.mode_o), 32'h0);
    for (int k = 0; k < 8; k++) drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("post reset out_valid", 32'(bus.out_valid), 32'h0);

`ifdef SKEW_ZERO_FILL_EN
    // Skew 0xFF vector; the monitor checks invalid lanes read zero every cycle.
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) drive(1'b0, 32'h0, 1'b1, 1'b1);
`endif

    for (int l = 0; l < LANES; l++) begin
      check($sformatf("lane%0d leftover", l), 32'(exp_q[l].size()), 32'h0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
